// File: rtl/alu_resp_pkg.sv
// Shared definitions for the ALU request/response unit.
//   - state_t    : control FSM states (IDLE, EXEC, RESP)
//   - DATA_W     : operand / result width (8)
//   - SEL_W      : operation select width (4)
//   - OP_MAX_DEF : default highest legal select code
//   - OP_*       : ALU operation codes
package alu_resp_pkg;

    localparam int DATA_W     = 8;
    localparam int SEL_W      = 4;
    localparam int OP_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] OP_ADD = 4'd0;  // {carry,out} = a + b
    localparam logic [SEL_W-1:0] OP_SUB = 4'd1;  // {borrow,out} = a - b
    localparam logic [SEL_W-1:0] OP_AND = 4'd2;
    localparam logic [SEL_W-1:0] OP_OR  = 4'd3;
    localparam logic [SEL_W-1:0] OP_XOR = 4'd4;
    localparam logic [SEL_W-1:0] OP_NOT = 4'd5;  // out = ~a
    localparam logic [SEL_W-1:0] OP_SHL = 4'd6;  // carry = a[7]
    localparam logic [SEL_W-1:0] OP_SHR = 4'd7;  // carry = a[0]
    localparam logic [SEL_W-1:0] OP_INC = 4'd8;  // {carry,out} = a + 1

endpackage

// File: rtl/alu_resp_unit_alu.sv
// Combinational 8-bit ALU.
// Ports:
//   a, b   : operands
//   sel    : operation code (see alu_resp_pkg OP_*)
//   out    : result
//   carry  : carry / borrow / shifted-out bit
//   flag   : zero flag for implemented codes; 0 for unimplemented codes
module alu_resp_unit_alu
    import alu_resp_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out,
    output logic              carry,
    output logic              flag
);

    logic [DATA_W:0] wide;
    logic            known;

    always_comb begin
        wide  = '0;
        out   = '0;
        carry = 1'b0;
        known = 1'b1;
        case (sel)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                out   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                out   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_NOT: out = ~a;
            OP_SHL: begin
                out   = {a[DATA_W-2:0], 1'b0};
                carry = a[DATA_W-1];
            end
            OP_SHR: begin
                out   = {1'b0, a[DATA_W-1:1]};
                carry = a[0];
            end
            OP_INC: begin
                wide  = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
                out   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            default: known = 1'b0;
        endcase
        flag = known && (out == '0);
    end

endmodule

// File: rtl/alu_resp_unit.sv
// Request/response wrapper around the combinational ALU.
// A request is captured in IDLE, evaluated in EXEC, and held in RESP until
// the consumer accepts it. Select codes above OP_MAX return an error
// response with all result fields zero.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake; req_ready high only in IDLE
//   req_a, req_b          : operands
//   req_select            : operation code
//   resp_valid/resp_ready : response handshake; resp_valid high only in RESP
//   resp_out/carry/flag   : registered ALU result
//   resp_err              : request had an illegal select
//   stat_ops, stat_err    : saturating completed-response counters
// Build option: define ALU_RESP_STATS_EN to implement the statistics
// counters; otherwise stat_ops/stat_err are tied to zero.
module alu_resp_unit
    import alu_resp_pkg::*;
#(
    parameter int OP_MAX = OP_MAX_DEF,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [SEL_W-1:0]  req_select,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_out,
    output logic              resp_carry,
    output logic              resp_flag,
    output logic              resp_err,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_err
);

    state_t state, state_next;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SEL_W-1:0]  op_sel;

    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              alu_flag;
    logic              illegal;
    logic              accept;
    logic              deliver;

    alu_resp_unit_alu u_alu (
        .a     (op_a),
        .b     (op_b),
        .sel   (op_sel),
        .out   (alu_out),
        .carry (alu_carry),
        .flag  (alu_flag)
    );

    assign illegal = int'(op_sel) > OP_MAX;
    assign accept  = req_valid && req_ready;
    assign deliver = resp_valid && resp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)  state_next = ST_EXEC;
            ST_EXEC:              state_next = ST_RESP;
            ST_RESP: if (deliver) state_next = ST_IDLE;
            default:              state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
    end

    // Operand capture on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= '0;
        end else if (accept) begin
            op_a   <= req_a;
            op_b   <= req_b;
            op_sel <= req_select;
        end
    end

    // Response capture in EXEC; fields then hold through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_out   <= '0;
            resp_carry <= 1'b0;
            resp_flag  <= 1'b0;
            resp_err   <= 1'b0;
        end else if (state == ST_EXEC) begin
            resp_err   <= illegal;
            resp_out   <= illegal ? '0   : alu_out;
            resp_carry <= illegal ? 1'b0 : alu_carry;
            resp_flag  <= illegal ? 1'b0 : alu_flag;
        end
    end

`ifdef ALU_RESP_STATS_EN
    // Counters advance on the response handshake and stick at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops <= '0;
            stat_err <= '0;
        end else if (deliver) begin
            if (stat_ops != '1)             stat_ops <= stat_ops + 1'b1;
            if (resp_err && stat_err != '1) stat_err <= stat_err + 1'b1;
        end
    end
`else
    assign stat_ops = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed testbench for alu_resp_unit (STAT_W = 4 to exercise saturation).
module tb_alu_resp_unit;

    localparam int STAT_W = 4;
`ifdef ALU_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_a;
    logic [7:0]        req_b;
    logic [3:0]        req_select;
    logic              resp_valid;
    logic              resp_ready;
    logic [7:0]        resp_out;
    logic              resp_carry;
    logic              resp_flag;
    logic              resp_err;
    logic [STAT_W-1:0] stat_ops;
    logic [STAT_W-1:0] stat_err;

    int n_vec = 0;
    int n_err = 0;

    alu_resp_unit #(.OP_MAX(8), .STAT_W(STAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_select (req_select),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_carry (resp_carry),
        .resp_flag  (resp_flag),
        .resp_err   (resp_err),
        .stat_ops   (stat_ops),
        .stat_err   (stat_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    // Called at a negedge or just after a posedge; returns at a negedge in IDLE.
    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Issue one request and check the response two clocks after acceptance.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [7:0] eo,
                         input logic ec, input logic ef, input logic ee);
        wait_ready();
        req_a = a; req_b = b; req_select = sel; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early_valid"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_out"},   32'(resp_out),   32'(eo));
        chk({tag, "_carry"}, 32'(resp_carry), 32'(ec));
        chk({tag, "_flag"},  32'(resp_flag),  32'(ef));
        chk({tag, "_err"},   32'(resp_err),   32'(ee));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_select = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_out",   32'(resp_out),   32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        chk("rst_stat_ops",   32'(stat_ops),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Reset during EXEC abandons the operation
        wait_ready();
        req_a = 8'd10; req_b = 8'd5; req_select = 4'd0; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rexec_valid", 32'(resp_valid), 32'd0);
        chk("rexec_ready", 32'(req_ready),  32'd1);
        @(negedge clk);
        chk("rexec_no_resp", 32'(resp_valid), 32'd0);

        // Reset during RESP abandons the held response
        resp_ready = 1'b0;
        req_a = 8'd200; req_b = 8'd100; req_select = 4'd0; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rresp_valid_before", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rresp_valid",    32'(resp_valid), 32'd0);
        chk("rresp_ready",    32'(req_ready),  32'd1);
        chk("rresp_out_zero", 32'(resp_out),   32'd0);
        chk("rresp_stat_ops", 32'(stat_ops),   32'd0);
        chk("rresp_stat_err", 32'(stat_err),   32'd0);
        resp_ready = 1'b1;

        // a=10, b=5 across all legal selects
        do_op("add", 8'd10, 8'd5, 4'd0, 8'd15,  1'b0, 1'b0, 1'b0);
        do_op("sub", 8'd10, 8'd5, 4'd1, 8'd5,   1'b0, 1'b0, 1'b0);
        do_op("and", 8'd10, 8'd5, 4'd2, 8'd0,   1'b0, 1'b1, 1'b0);
        do_op("or",  8'd10, 8'd5, 4'd3, 8'd15,  1'b0, 1'b0, 1'b0);
        do_op("xor", 8'd10, 8'd5, 4'd4, 8'd15,  1'b0, 1'b0, 1'b0);
        do_op("not", 8'd10, 8'd5, 4'd5, 8'd245, 1'b0, 1'b0, 1'b0);
        do_op("shl", 8'd10, 8'd5, 4'd6, 8'd20,  1'b0, 1'b0, 1'b0);
        do_op("shr", 8'd10, 8'd5, 4'd7, 8'd5,   1'b0, 1'b0, 1'b0);
        do_op("inc", 8'd10, 8'd5, 4'd8, 8'd11,  1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("stat_ops_9", 32'(stat_ops), st(9));

        // Illegal selects
        do_op("ill9",  8'd10, 8'd5, 4'd9,  8'd0, 1'b0, 1'b0, 1'b1);
        do_op("ill15", 8'hFF, 8'h01, 4'd15, 8'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("stat_err_2",  32'(stat_err), st(2));
        chk("stat_ops_11", 32'(stat_ops), st(11));

        // Back-pressure: response holds while new requests are offered
        wait_ready();
        resp_ready = 1'b0;
        req_a = 8'd200; req_b = 8'd100; req_select = 4'd0; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid0", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 req_valid = (i % 2 == 0); req_a = 8'(i * 3 + 1); req_b = 8'd7; req_select = 4'd1;
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_ready", 32'(req_ready),  32'd0);
            chk("bp_out",   32'(resp_out),   32'd44);
            chk("bp_carry", 32'(resp_carry), 32'd1);
            chk("bp_flag",  32'(resp_flag),  32'd0);
            chk("bp_err",   32'(resp_err),   32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready),  32'd1);
        @(negedge clk);
        chk("bp_no_dup", 32'(resp_valid), 32'd0);
        chk("stat_ops_12", 32'(stat_ops), st(12));

        // Carry / borrow / shift-out cases
        do_op("sub_borrow", 8'd5,   8'd10, 4'd1, 8'd251,  1'b1, 1'b0, 1'b0);
        do_op("shl_carry",  8'h81,  8'd0,  4'd6, 8'h02,   1'b1, 1'b0, 1'b0);
        do_op("shr_carry",  8'h81,  8'd0,  4'd7, 8'h40,   1'b1, 1'b0, 1'b0);
        do_op("inc_wrap",   8'hFF,  8'd0,  4'd8, 8'h00,   1'b1, 1'b1, 1'b0);

        // Further legal ops: 20 legal, 22 responses total -> saturation
        for (int i = 0; i < 6; i++) begin
            do_op("sat_add", 8'(i), 8'd1, 4'd0, 8'(i + 1), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("stat_ops_sat", 32'(stat_ops), st(15));
        chk("stat_err_end", 32'(stat_err), st(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
